// File: rtl/rob_param_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
package rob_param_pkg;

  localparam int unsigned PREG_W_DEF = 7;
  localparam int unsigned PC_W       = 32;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_BR,
    WB_LD,
    WB_ST
  } wb_chan_e;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [PREG_W_DEF-1:0] pd_new;
    logic [PREG_W_DEF-1:0] pd_old;
    logic [PC_W-1:0]       pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire lane selection: contiguous valid&&done prefix from head, capped by RETIRE_W and i_count.
module rob_retire_sel #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RETIRE_W = 2,
  localparam int unsigned TAG_W   = $clog2(DEPTH),
  localparam int unsigned RC_W    = $clog2(RETIRE_W + 1)
) (
  input  logic [DEPTH-1:0]    i_valid,
  input  logic [DEPTH-1:0]    i_done,
  input  logic [TAG_W-1:0]    i_head,
  input  logic [TAG_W:0]      i_count,
  output logic [RETIRE_W-1:0] o_retire_valid,
  output logic [RC_W-1:0]     o_retire_cnt
);

  always_comb begin
    logic             w_run;
    logic [TAG_W-1:0] w_idx;
    w_run          = 1'b1;
    w_idx          = '0;
    o_retire_valid = '0;
    o_retire_cnt   = '0;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      w_idx = i_head + TAG_W'(k);
      w_run = w_run && i_valid[w_idx] && i_done[w_idx] && ((TAG_W+1)'(k) < i_count);
      o_retire_valid[k] = w_run;
      if (w_run) o_retire_cnt = o_retire_cnt + RC_W'(1);
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: allocate at tail, multi-channel completion, in-order multi-wide
// retire, tag squash. Optional completion checking via `define ROB_PARAM_WB_CHECK_EN.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NUM_WB   = 4,
  parameter int unsigned RETIRE_W = 2,
  parameter int unsigned PREG_W   = PREG_W_DEF,
  localparam int unsigned TAG_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [PREG_W-1:0]          alloc_pd_new,
  input  logic [PREG_W-1:0]          alloc_pd_old,
  input  logic [31:0]                alloc_pc,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic                       br_mispredict,
  input  logic [TAG_W-1:0]           br_mispredict_tag,
  output logic                       mispredict,
  output logic [TAG_W-1:0]           mispredict_tag,
  output logic [RETIRE_W-1:0]        retire_valid,
  output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
  output logic [TAG_W-1:0]           head,
  output logic [TAG_W:0]             count,
  output logic                       wb_err
);

  localparam int unsigned RC_W = $clog2(RETIRE_W + 1);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [PREG_W-1:0] r_pd_old [DEPTH];
  logic [PREG_W-1:0] r_pd_new [DEPTH];
  logic [31:0]       r_pc     [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;
  logic              r_mispredict;
  logic [TAG_W-1:0]  r_mispredict_tag;

  logic [TAG_W-1:0]    w_br_age;
  logic [TAG_W:0]      w_br_span;
  logic [TAG_W:0]      w_ret_cap;
  logic [RETIRE_W-1:0] w_ret_valid;
  logic [RC_W-1:0]     w_ret_cnt;
  logic                w_alloc;
  logic [DEPTH-1:0]    w_valid_nxt;
  logic [DEPTH-1:0]    w_done_nxt;
  logic [TAG_W:0]      w_count_nxt;
  logic                w_unused;

  assign w_br_age  = br_mispredict_tag - r_head;
  assign w_br_span = {1'b0, w_br_age} + (TAG_W+1)'(1);
  // During a squash the retire window ends at the branch, so younger done entries are never freed.
  assign w_ret_cap = (br_mispredict && (w_br_span < r_count)) ? w_br_span : r_count;

  rob_retire_sel #(
    .DEPTH    (DEPTH),
    .RETIRE_W (RETIRE_W)
  ) u_retire_sel (
    .i_valid        (r_valid),
    .i_done         (r_done),
    .i_head         (r_head),
    .i_count        (w_ret_cap),
    .o_retire_valid (w_ret_valid),
    .o_retire_cnt   (w_ret_cnt)
  );

  assign alloc_ready    = (r_count < FULL) && !br_mispredict;
  assign w_alloc        = alloc_valid && alloc_ready;
  assign alloc_tag      = r_tail;
  assign head           = r_head;
  assign count          = r_count;
  assign mispredict     = r_mispredict;
  assign mispredict_tag = r_mispredict_tag;
  assign retire_valid   = w_ret_valid;

  always_comb begin
    retire_pd_old = '0;
    for (int unsigned k = 0; k < RETIRE_W; k++)
      retire_pd_old[k*PREG_W +: PREG_W] = r_pd_old[r_head + TAG_W'(k)];
  end

  always_comb begin
    logic [TAG_W-1:0] w_idx;
    logic [TAG_W-1:0] w_age;
    w_idx       = '0;
    w_age       = '0;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_count_nxt = '0;
    for (int unsigned k = 0; k < RETIRE_W; k++) begin
      w_idx = r_head + TAG_W'(k);
      if (w_ret_valid[k]) w_valid_nxt[w_idx] = 1'b0;
    end
    if (br_mispredict) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_age = TAG_W'(i) - r_head;
        if (w_age > w_br_age) w_valid_nxt[i] = 1'b0;
      end
    end
    // Checking the post-squash valid drops completions to squashed entries.
    for (int unsigned c = 0; c < NUM_WB; c++) begin
      w_idx = wb_tag[c*TAG_W +: TAG_W];
      if (wb_valid[c] && w_valid_nxt[w_idx]) w_done_nxt[w_idx] = 1'b1;
    end
    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
      w_done_nxt[r_tail]  = 1'b0;
    end
    for (int unsigned i = 0; i < DEPTH; i++)
      w_count_nxt = w_count_nxt + (TAG_W+1)'(w_valid_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid          <= '0;
      r_done           <= '0;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_mispredict     <= 1'b0;
      r_mispredict_tag <= '0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_done       <= w_done_nxt;
      r_count      <= w_count_nxt;
      r_head       <= r_head + TAG_W'(w_ret_cnt);
      r_mispredict <= br_mispredict;
      if (br_mispredict) begin
        r_tail           <= br_mispredict_tag + TAG_W'(1);
        r_mispredict_tag <= br_mispredict_tag;
      end else if (w_alloc) begin
        r_tail <= r_tail + TAG_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_pd_old[r_tail] <= alloc_pd_old;
      r_pd_new[r_tail] <= alloc_pd_new;
      r_pc[r_tail]     <= alloc_pc;
    end
  end

  // pd_new and pc travel with the entry for downstream consumers not present in this slice.
  always_comb begin
    w_unused = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      w_unused = w_unused ^ (^{r_pd_new[i], r_pc[i]});
  end

`ifdef ROB_PARAM_WB_CHECK_EN
  logic r_wb_err;
  logic w_wb_bad;

  always_comb begin
    logic [TAG_W-1:0] w_t;
    w_t      = '0;
    w_wb_bad = 1'b0;
    for (int unsigned c = 0; c < NUM_WB; c++) begin
      w_t = wb_tag[c*TAG_W +: TAG_W];
      if (wb_valid[c] && (!r_valid[w_t] || r_done[w_t])) w_wb_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_wb_err <= 1'b0;
    else if (w_wb_bad) r_wb_err <= 1'b1;
  end

  assign wb_err = r_wb_err;
`else
  assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: queue-based ROB model plus directed scenarios and random traffic.
module tb_rob_param;

  localparam int DEPTH    = 16;
  localparam int NUM_WB   = 4;
  localparam int RETIRE_W = 2;
  localparam int PREG_W   = 7;
  localparam int TAG_W    = 4;
`ifdef ROB_PARAM_WB_CHECK_EN
  localparam bit WB_CHECK = 1'b1;
`else
  localparam bit WB_CHECK = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       alloc_valid = 1'b0;
  logic [PREG_W-1:0]          alloc_pd_new = '0;
  logic [PREG_W-1:0]          alloc_pd_old = '0;
  logic [31:0]                alloc_pc = '0;
  logic                       alloc_ready;
  logic [TAG_W-1:0]           alloc_tag;
  logic [NUM_WB-1:0]          wb_valid = '0;
  logic [NUM_WB*TAG_W-1:0]    wb_tag = '0;
  logic                       br_mispredict = 1'b0;
  logic [TAG_W-1:0]           br_mispredict_tag = '0;
  logic                       mispredict;
  logic [TAG_W-1:0]           mispredict_tag;
  logic [RETIRE_W-1:0]        retire_valid;
  logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
  logic [TAG_W-1:0]           head;
  logic [TAG_W:0]             count;
  logic                       wb_err;

  always #5 clk = ~clk;

  rob_param #(
    .DEPTH    (DEPTH),
    .NUM_WB   (NUM_WB),
    .RETIRE_W (RETIRE_W),
    .PREG_W   (PREG_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_valid       (alloc_valid),
    .alloc_pd_new      (alloc_pd_new),
    .alloc_pd_old      (alloc_pd_old),
    .alloc_pc          (alloc_pc),
    .alloc_ready       (alloc_ready),
    .alloc_tag         (alloc_tag),
    .wb_valid          (wb_valid),
    .wb_tag            (wb_tag),
    .br_mispredict     (br_mispredict),
    .br_mispredict_tag (br_mispredict_tag),
    .mispredict        (mispredict),
    .mispredict_tag    (mispredict_tag),
    .retire_valid      (retire_valid),
    .retire_pd_old     (retire_pd_old),
    .head              (head),
    .count             (count),
    .wb_err            (wb_err)
  );

  int errors = 0;
  int checks = 0;

  // Model: occupied entries in age order (index 0 = oldest).
  int q_tag[$];
  int q_pdo[$];
  bit q_done[$];
  int m_head = 0;
  bit m_misp = 0;
  int m_mtag = 0;
  bit m_err  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_nret();
    int cap, n;
    cap = q_tag.size();
    if (br_mispredict) begin
      int p;
      p = (int'(br_mispredict_tag) - m_head) & (DEPTH - 1);
      if (p + 1 < cap) cap = p + 1;
    end
    n = 0;
    while (n < RETIRE_W && n < cap && q_done[n]) n++;
    return n;
  endfunction

  task automatic check_model();
    int sz, n;
    logic [RETIRE_W-1:0] rv;
    sz = q_tag.size();
    n  = exp_nret();
    rv = '0;
    chk("alloc_ready", alloc_ready, (sz < DEPTH) && !br_mispredict);
    chk("alloc_tag", alloc_tag, (m_head + sz) % DEPTH);
    chk("head", head, m_head);
    chk("count", count, sz);
    for (int k = 0; k < n; k++) begin
      rv[k] = 1'b1;
      chk("retire_pd_old", retire_pd_old[k*PREG_W +: PREG_W], q_pdo[k]);
    end
    chk("retire_valid", retire_valid, rv);
    chk("mispredict", mispredict, m_misp);
    chk("mispredict_tag", mispredict_tag, m_mtag);
    chk("wb_err", wb_err, m_err);
  endtask

  task automatic model_update();
    int sz, n, p, t, a, ntail;
    bit bad;
    bit hit[DEPTH];
    sz    = q_tag.size();
    n     = exp_nret();
    p     = DEPTH;
    bad   = 1'b0;
    ntail = (m_head + sz) % DEPTH;
    foreach (hit[i]) hit[i] = 1'b0;
    if (br_mispredict) p = (int'(br_mispredict_tag) - m_head) & (DEPTH - 1);
    for (int c = 0; c < NUM_WB; c++) begin
      if (wb_valid[c]) begin
        t = int'(wb_tag[c*TAG_W +: TAG_W]);
        a = (t - m_head) & (DEPTH - 1);
        if (a >= sz || q_done[a]) bad = 1'b1;
        else if (a <= p) hit[a] = 1'b1;
      end
    end
    m_err = m_err | (bad & WB_CHECK);
    for (int i = 0; i < sz; i++) if (hit[i]) q_done[i] = 1'b1;
    while (q_tag.size() > p + 1) begin
      void'(q_tag.pop_back());
      void'(q_pdo.pop_back());
      void'(q_done.pop_back());
    end
    for (int i = 0; i < n; i++) begin
      void'(q_tag.pop_front());
      void'(q_pdo.pop_front());
      void'(q_done.pop_front());
    end
    m_head = (m_head + n) % DEPTH;
    if (alloc_valid && sz < DEPTH && !br_mispredict) begin
      q_tag.push_back(ntail);
      q_pdo.push_back(int'(alloc_pd_old));
      q_done.push_back(1'b0);
    end
    m_misp = br_mispredict;
    if (br_mispredict) m_mtag = int'(br_mispredict_tag);
  endtask

  task automatic idle();
    alloc_valid   = 1'b0;
    wb_valid      = '0;
    wb_tag        = '0;
    br_mispredict = 1'b0;
  endtask

  task automatic alloc(input int pdo);
    alloc_valid  = 1'b1;
    alloc_pd_old = PREG_W'(pdo);
    alloc_pd_new = PREG_W'($urandom);
    alloc_pc     = $urandom;
  endtask

  task automatic set_wb(input int c, input int t);
    wb_valid[c]              = 1'b1;
    wb_tag[c*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic squash(input int t);
    br_mispredict     = 1'b1;
    br_mispredict_tag = TAG_W'(t);
  endtask

  task automatic cyc();
    #1 check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    q_tag.delete();
    q_pdo.delete();
    q_done.delete();
    m_head = 0;
    m_misp = 0;
    m_mtag = 0;
    m_err  = 0;
    @(negedge clk);
    #1 check_model();
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_retire_valid", retire_valid, 0);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill to DEPTH: tags 0..15 then alloc_ready drops.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc(i + 10); cyc(); chk("fill_alloc_tag", alloc_tag, i); tick();
    end
    alloc(0); cyc(); chk("fill_count", count, 16); chk("fill_ready", alloc_ready, 0); tick();

    // Out-of-order completion of 0..3 in one cycle, then two-wide retirement.
    do_reset();
    for (int i = 0; i < 4; i++) begin alloc(20 + i); cyc(); tick(); end
    set_wb(0, 3); set_wb(1, 2); set_wb(2, 1); set_wb(3, 0); cyc();
    chk("ooo_rv_same_cycle", retire_valid, 0); tick();
    cyc(); chk("ooo_rv_a", retire_valid, 2'b11);
    chk("ooo_pd_a0", retire_pd_old[0 +: PREG_W], 20); chk("ooo_pd_a1", retire_pd_old[PREG_W +: PREG_W], 21); tick();
    cyc(); chk("ooo_rv_b", retire_valid, 2'b11);
    chk("ooo_pd_b0", retire_pd_old[0 +: PREG_W], 22); chk("ooo_pd_b1", retire_pd_old[PREG_W +: PREG_W], 23); tick();
    cyc(); chk("ooo_count", count, 0); tick();

    // Wrap-around from head=14.
    do_reset();
    for (int i = 0; i < 14; i++) begin alloc(i); cyc(); tick(); end
    for (int b = 0; b < 14; b += 4) begin
      for (int c = 0; c < NUM_WB; c++) if (b + c < 14) set_wb(c, b + c);
      cyc(); tick();
    end
    for (int i = 0; i < 6; i++) begin cyc(); tick(); end
    cyc(); chk("wrap_head14", head, 14); chk("wrap_empty", count, 0); tick();
    for (int i = 0; i < 4; i++) begin
      alloc(40 + i); cyc(); chk("wrap_alloc_tag", alloc_tag, (14 + i) % 16); tick();
    end
    set_wb(0, 14); set_wb(1, 15); set_wb(2, 0); set_wb(3, 1); cyc(); tick();
    cyc(); chk("wrap_pd14", retire_pd_old[0 +: PREG_W], 40); tick();
    cyc(); chk("wrap_pd0", retire_pd_old[0 +: PREG_W], 42); tick();
    cyc(); chk("wrap_head2", head, 2); tick();

    // Squash at tag 7 with entries 5..10 live; completion to 9 in the same cycle is dropped.
    do_reset();
    for (int i = 0; i < 11; i++) begin alloc(60 + i); cyc(); tick(); end
    for (int c = 0; c < 4; c++) set_wb(c, c);
    cyc(); tick();
    set_wb(0, 4); cyc(); tick();
    for (int i = 0; i < 3; i++) begin cyc(); tick(); end
    squash(7); set_wb(0, 9); alloc(1); cyc();
    chk("sq_head", head, 5); chk("sq_count_pre", count, 6); chk("sq_ready", alloc_ready, 0); tick();
    cyc(); chk("sq_pulse", mispredict, 1); chk("sq_tag", mispredict_tag, 7);
    chk("sq_tail", alloc_tag, 8); chk("sq_count", count, 3); tick();
    cyc(); chk("sq_pulse_end", mispredict, 0); tick();
    alloc(90); cyc(); tick();
    alloc(91); cyc(); tick();
    set_wb(0, 5); set_wb(1, 6); set_wb(2, 7); set_wb(3, 8); cyc(); tick();
    for (int i = 0; i < 4; i++) begin cyc(); tick(); end
    cyc(); chk("sq_tag9_not_done", count, 1); tick();

    // Squash, allocate and retire of a done head in the same cycle; then back-to-back squashes.
    do_reset();
    for (int i = 0; i < 6; i++) begin alloc(70 + i); cyc(); tick(); end
    set_wb(0, 0); cyc(); tick();
    alloc(99); squash(4); cyc();
    chk("sim_ready", alloc_ready, 0); chk("sim_rv", retire_valid, 2'b01); tick();
    squash(3); cyc();
    chk("sim_head", head, 1); chk("sim_count", count, 4); chk("sim_tail", alloc_tag, 5); tick();
    squash(2); cyc(); chk("b2b_tag_a", mispredict_tag, 3); tick();
    cyc(); chk("b2b_pulse", mispredict, 1); chk("b2b_tag_b", mispredict_tag, 2); tick();

    // Completion to an empty entry.
    do_reset();
    set_wb(0, 5); cyc(); tick();
    cyc(); chk("wberr_set", wb_err, WB_CHECK); tick();
    for (int i = 0; i < 3; i++) begin cyc(); tick(); end
    cyc(); chk("wberr_held", wb_err, WB_CHECK); tick();

    // Random traffic against the model.
    do_reset();
    for (int cy = 0; cy < 3000; cy++) begin
      int sz;
      sz = q_tag.size();
      if ($urandom_range(3, 0) != 0) alloc($urandom_range(127, 0));
      for (int c = 0; c < NUM_WB; c++) begin
        if ($urandom_range(1, 0) == 1) begin
          if (sz > 0 && $urandom_range(7, 0) != 0) set_wb(c, q_tag[$urandom_range(sz - 1, 0)]);
          else set_wb(c, $urandom_range(DEPTH - 1, 0));
        end
      end
      if (sz > 0 && $urandom_range(15, 0) == 0) squash(q_tag[$urandom_range(sz - 1, 0)]);
      cyc();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
